// File: rtl/nova_bs_pkg.sv
// nova_bs_pkg: shared bitstream-parser widths and length-source indices
package nova_bs_pkg;
  localparam int LEN_W  = 5;
  localparam int WORD_W = 16;
  localparam int WIN_W  = 16;
  typedef enum logic [2:0] {
    SRC_NC_T1       = 3'd0,
    SRC_T1_SIGN     = 3'd1,
    SRC_LVL_PREFIX  = 3'd2,
    SRC_LVL_SUFFIX  = 3'd3,
    SRC_TOTAL_ZEROS = 3'd4,
    SRC_RUN_BEFORE  = 3'd5,
    SRC_EXPGOLOMB   = 3'd6,
    SRC_FIXED       = 3'd7
  } src_e;
endpackage

// File: rtl/bitstream_consume_buffer_if.sv
// bitstream_consume_buffer_if: valid/ready word stream from the bitstream FIFO
interface bitstream_consume_buffer_if #(parameter int WORD_W = 16);
  logic [WORD_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/bs_len_select.sv
// bs_len_select: NSRC:1 consumed-length mux with source and window range check
module bs_len_select #(
  parameter int LEN_W = 5,
  parameter int NSRC  = 8,
  parameter int WIN_W = 16
) (
  input  logic [NSRC*LEN_W-1:0]    i_src_len,
  input  logic [$clog2(NSRC)-1:0]  i_src_sel,
  output logic [LEN_W-1:0]         o_len,
  output logic                     o_len_ok
);
  logic w_sel_err;
  always_comb begin
    w_sel_err = int'(i_src_sel) >= NSRC;
    o_len     = w_sel_err ? '0 : i_src_len[int'(i_src_sel)*LEN_W +: LEN_W];
    o_len_ok  = !w_sel_err && (int'(o_len) <= WIN_W);
  end
endmodule

// File: rtl/bitstream_consume_buffer.sv
// bitstream_consume_buffer: MSB-first shift buffer refilled from a word FIFO, advanced by selected lengths
module bitstream_consume_buffer #(
  parameter int WORD_W = nova_bs_pkg::WORD_W,
  parameter int WIN_W  = nova_bs_pkg::WIN_W,
  parameter int BUF_W  = 64,
  parameter int LEN_W  = nova_bs_pkg::LEN_W,
  parameter int NSRC   = 8,
  parameter int POS_W  = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [NSRC*LEN_W-1:0]      src_len,
  input  logic [$clog2(NSRC)-1:0]    src_sel,
  input  logic                       consume_en,
  input  logic                       align_req,
  bitstream_consume_buffer_if.slave  bs,
  output logic [WIN_W-1:0]           win_data,
  output logic                       win_valid,
  output logic [LEN_W-1:0]           consumed_len,
  output logic [POS_W-1:0]           bit_pos,
  output logic                       err_len
);
  localparam int LVL_W = $clog2(BUF_W + 1);
  logic [BUF_W-1:0] r_buf;
  logic [LVL_W-1:0] r_lvl;
  logic [POS_W-1:0] r_pos;
  logic             r_err;
  logic [LEN_W-1:0] w_len;
  logic             w_len_ok, w_cons_req, w_fire_cons, w_fire_align, w_push;
  logic [2:0]       w_align_len;
  logic [LVL_W-1:0] w_lvl_cons, w_lvl_next;
  logic [BUF_W-1:0] w_buf_next;

  bs_len_select #(.LEN_W(LEN_W), .NSRC(NSRC), .WIN_W(WIN_W)) u_len_select (
    .i_src_len (src_len),
    .i_src_sel (src_sel),
    .o_len     (w_len),
    .o_len_ok  (w_len_ok)
  );

  assign bs.in_ready = r_lvl <= LVL_W'(BUF_W - WORD_W);
  assign win_valid   = r_lvl >= LVL_W'(WIN_W);
  assign win_data    = r_buf[BUF_W-1 -: WIN_W];
  assign bit_pos     = r_pos;
  assign err_len     = r_err;

  // The new word lands right behind the bits that survive this cycle's consume
  always_comb begin
    w_cons_req   = consume_en && !align_req && win_valid && !flush;
    w_fire_cons  = w_cons_req && w_len_ok;
    w_fire_align = align_req && win_valid && !flush;
    w_align_len  = 3'd0 - r_pos[2:0];
    consumed_len = w_fire_align ? LEN_W'(w_align_len) : w_fire_cons ? w_len : '0;
    w_push       = bs.in_valid && bs.in_ready;
    w_lvl_cons   = r_lvl - LVL_W'(consumed_len);
    w_lvl_next   = w_lvl_cons + (w_push ? LVL_W'(WORD_W) : LVL_W'(0));
    w_buf_next   = (r_buf << consumed_len)
                 | (w_push ? ({bs.in_data, {(BUF_W-WORD_W){1'b0}}} >> w_lvl_cons) : '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_buf <= '0;
      r_lvl <= '0;
      r_pos <= '0;
      r_err <= 1'b0;
    end else if (flush) begin
      r_buf <= '0;
      r_lvl <= '0;
      r_pos <= '0;
    end else begin
      r_buf <= w_buf_next;
      r_lvl <= w_lvl_next;
      r_pos <= r_pos + POS_W'(consumed_len);
      if (w_cons_req && !w_len_ok) r_err <= 1'b1;
    end
  end
endmodule
